// File: rtl/pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl : miniRV 5-stage controller (decode, stage control regs,    |
// |             load-use/RAW stall, forwarding selects, EX branch flush)  |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int FWD_EN = 1,
  parameter int RA_W   = 5
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  input  logic [31:0]     id_inst,
  input  logic            ex_zero,
  input  logic            ex_sgn,
  output logic [2:0]      id_sext_op,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alub_sel,
  output logic [1:0]      ex_npc_op,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mem_dram_we,
  output logic            wb_rf_we,
  output logic [1:0]      wb_rf_wsel,
  output logic [RA_W-1:0] wb_rd
);

  localparam logic [1:0] c_NPC_PC4     = 2'b00;
  localparam logic [1:0] c_NPC_PC_IMM  = 2'b01;
  localparam logic [1:0] c_NPC_RD1_IMM = 2'b10;

  localparam logic [2:0] c_EXT_I     = 3'b000;
  localparam logic [2:0] c_EXT_S     = 3'b001;
  localparam logic [2:0] c_EXT_B     = 3'b010;
  localparam logic [2:0] c_EXT_U     = 3'b011;
  localparam logic [2:0] c_EXT_J     = 3'b100;
  localparam logic [2:0] c_EXT_SHIFT = 3'b101;

  localparam logic [1:0] c_WB_ALU  = 2'b00;
  localparam logic [1:0] c_WB_DRAM = 2'b01;
  localparam logic [1:0] c_WB_PC4  = 2'b10;
  localparam logic [1:0] c_WB_EXT  = 2'b11;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;
  localparam logic [2:0] c_ALU_SLL = 3'b101;
  localparam logic [2:0] c_ALU_SRL = 3'b110;
  localparam logic [2:0] c_ALU_SRA = 3'b111;

  localparam logic c_ALUB_RF  = 1'b0;
  localparam logic c_ALUB_EXT = 1'b1;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB  = 2'b10;

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD = 7'b0000011;
  localparam logic [6:0] c_OP_S    = 7'b0100011;
  localparam logic [6:0] c_OP_B    = 7'b1100011;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  localparam logic [2:0] c_F3_BEQ = 3'b000;
  localparam logic [2:0] c_F3_BNE = 3'b001;
  localparam logic [2:0] c_F3_BLT = 3'b100;
  localparam logic [2:0] c_F3_BGE = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            rf_we;
    logic            dram_we;
    logic [1:0]      rf_wsel;
    logic [2:0]      alu_op;
    logic            alub_sel;
    logic            is_load;
    logic            is_jal;
    logic            is_jalr;
    logic            is_br;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rs1_used;
    logic            rs2_used;
  } ctrl_t;

  function automatic ctrl_t f_bubble();
    ctrl_t b;
    b          = '0;
    b.rf_wsel  = c_WB_PC4;
    b.alu_op   = c_ALU_ADD;
    b.alub_sel = c_ALUB_RF;
    return b;
  endfunction

  function automatic logic [2:0] f_alu(input logic [2:0] f3, input logic f7b5, input logic is_r);
    logic [2:0] op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b111:  op = c_ALU_AND;
      3'b110:  op = c_ALU_OR;
      3'b100:  op = c_ALU_XOR;
      3'b001:  op = c_ALU_SLL;
      3'b101:  op = f7b5 ? c_ALU_SRA : c_ALU_SRL;
      default: op = c_ALU_ADD;
    endcase
    return op;
  endfunction

  // Producer stage s writes a register that the consumer reads through rs.
  function automatic logic f_match(input ctrl_t s, input logic [RA_W-1:0] rs, input logic used);
    return s.valid && s.rf_we && (s.rd != '0) && used && (s.rd == rs);
  endfunction

  logic       r_id_valid;
  ctrl_t      r_ex;
  ctrl_t      r_mem;
  ctrl_t      r_wb;
  ctrl_t      w_id;
  logic [2:0] w_sext;
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_m_ex;
  logic       w_m_mem;
  logic       w_m_wb;
  logic       w_load_use;
  logic       w_raw_stall;
  logic       w_stall;
  logic       w_br_take;
  logic       w_taken;
  logic       w_unused;

  assign w_opc  = id_inst[6:0];
  assign w_f3   = id_inst[14:12];
  assign w_f7b5 = id_inst[30];

  always_comb begin
    w_id          = f_bubble();
    w_sext        = c_EXT_I;
    w_id.valid    = 1'b1;
    w_id.funct3   = w_f3;
    w_id.rd       = RA_W'(id_inst[11:7]);
    w_id.rs1      = RA_W'(id_inst[19:15]);
    w_id.rs2      = RA_W'(id_inst[24:20]);
    case (w_opc)
      c_OP_R: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_ALU;
        w_id.alu_op   = f_alu(w_f3, w_f7b5, 1'b1);
        w_id.rs1_used = 1'b1;
        w_id.rs2_used = 1'b1;
      end
      c_OP_I: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_ALU;
        w_id.alub_sel = c_ALUB_EXT;
        w_id.alu_op   = f_alu(w_f3, w_f7b5, 1'b0);
        w_id.rs1_used = 1'b1;
        w_sext        = (w_f3 == 3'b001 || w_f3 == 3'b101) ? c_EXT_SHIFT : c_EXT_I;
      end
      c_OP_LOAD: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_DRAM;
        w_id.alub_sel = c_ALUB_EXT;
        w_id.is_load  = 1'b1;
        w_id.rs1_used = 1'b1;
      end
      c_OP_S: begin
        w_id.dram_we  = 1'b1;
        w_id.alub_sel = c_ALUB_EXT;
        w_id.rs1_used = 1'b1;
        w_id.rs2_used = 1'b1;
        w_sext        = c_EXT_S;
      end
      c_OP_B: begin
        w_id.alu_op   = c_ALU_SUB;
        w_id.is_br    = 1'b1;
        w_id.rs1_used = 1'b1;
        w_id.rs2_used = 1'b1;
        w_sext        = c_EXT_B;
      end
      c_OP_LUI: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_EXT;
        w_sext        = c_EXT_U;
      end
      c_OP_JAL: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_PC4;
        w_id.is_jal   = 1'b1;
        w_sext        = c_EXT_J;
      end
      c_OP_JALR: begin
        w_id.rf_we    = 1'b1;
        w_id.rf_wsel  = c_WB_PC4;
        w_id.alub_sel = c_ALUB_EXT;
        w_id.is_jalr  = 1'b1;
        w_id.rs1_used = 1'b1;
      end
      default: ;
    endcase
    if (!r_id_valid) begin
      w_id = f_bubble();
    end
  end

  assign id_sext_op = w_sext;

  assign w_m_ex  = f_match(r_ex,  w_id.rs1, w_id.rs1_used) || f_match(r_ex,  w_id.rs2, w_id.rs2_used);
  assign w_m_mem = f_match(r_mem, w_id.rs1, w_id.rs1_used) || f_match(r_mem, w_id.rs2, w_id.rs2_used);
  assign w_m_wb  = f_match(r_wb,  w_id.rs1, w_id.rs1_used) || f_match(r_wb,  w_id.rs2, w_id.rs2_used);
  assign w_load_use = w_m_ex && r_ex.is_load;

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign w_raw_stall = 1'b0;
      // Loads in EX/MEM are never a bypass source; the load-use stall covers them.
      always_comb begin
        fwd_a = c_FWD_RF;
        fwd_b = c_FWD_RF;
        if (f_match(r_mem, r_ex.rs1, r_ex.rs1_used) && !r_mem.is_load) begin
          fwd_a = c_FWD_MEM;
        end else if (f_match(r_wb, r_ex.rs1, r_ex.rs1_used)) begin
          fwd_a = c_FWD_WB;
        end
        if (f_match(r_mem, r_ex.rs2, r_ex.rs2_used) && !r_mem.is_load) begin
          fwd_b = c_FWD_MEM;
        end else if (f_match(r_wb, r_ex.rs2, r_ex.rs2_used)) begin
          fwd_b = c_FWD_WB;
        end
      end
    end else begin : g_nofwd
      // No RF bypass either, so a WB-stage producer still holds the consumer.
      assign w_raw_stall = w_m_ex || w_m_mem || w_m_wb;
      assign fwd_a       = c_FWD_RF;
      assign fwd_b       = c_FWD_RF;
    end
  endgenerate

  assign w_stall = w_load_use || w_raw_stall;

  always_comb begin
    w_br_take = 1'b0;
    case (r_ex.funct3)
      c_F3_BEQ: w_br_take = ex_zero;
      c_F3_BNE: w_br_take = !ex_zero;
      c_F3_BLT: w_br_take = ex_sgn;
      c_F3_BGE: w_br_take = !ex_sgn;
      default:  w_br_take = 1'b0;
    endcase
    w_taken   = r_ex.valid && (r_ex.is_jal || r_ex.is_jalr || (r_ex.is_br && w_br_take));
    ex_npc_op = c_NPC_PC4;
    if (r_ex.valid && r_ex.is_jalr) begin
      ex_npc_op = c_NPC_RD1_IMM;
    end else if (w_taken) begin
      ex_npc_op = c_NPC_PC_IMM;
    end
  end

  assign ifid_flush = w_taken;
  assign pc_stall   = w_stall && !w_taken;
  assign ifid_stall = w_stall && !w_taken;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      r_id_valid <= 1'b0;
      r_ex       <= f_bubble();
      r_mem      <= f_bubble();
      r_wb       <= f_bubble();
    end else begin
      r_id_valid <= !w_taken;
      r_ex       <= (w_taken || w_stall) ? f_bubble() : w_id;
      r_mem      <= r_ex;
      r_wb       <= r_mem;
    end
  end

  assign ex_alu_op   = r_ex.alu_op;
  assign ex_alub_sel = r_ex.alub_sel;
  assign mem_dram_we = r_mem.valid && r_mem.dram_we;
  assign wb_rf_we    = r_wb.valid && r_wb.rf_we;
  assign wb_rf_wsel  = r_wb.rf_wsel;
  assign wb_rd       = r_wb.rd;

  assign w_unused = ^{id_inst, r_ex, r_mem, r_wb};

endmodule
`default_nettype wire
